// File: rtl/input_unit_if.sv
// Operator-input bundle between the processor/board side and input_unit.
// No latency of its own; it only groups the request, switch, key and result wires.
// Backpressure: the processor holds flagIN and stalls while busy; there are no other stalls.
interface input_unit_if #(
   parameter int SW_W   = 10,
   parameter int DATA_W = 32
);
   logic              flagIN;
   logic [SW_W-1:0]   switches;
   logic              key_n;
   logic [DATA_W-1:0] value;
   logic              ready;
   logic              busy;
   logic              wait_led;

   // Processor/board side: drives the request, switches and key, and receives the result.
   modport master (
      output flagIN, switches, key_n,
      input  value, ready, busy, wait_led
   );

   // Peripheral side.
   modport slave (
      input  flagIN, switches, key_n,
      output value, ready, busy, wait_led
   );
endinterface

// File: rtl/input_unit.sv
// Operator input peripheral: waits for a debounced key press, then returns the sign-extended switch value.
// Latency: ready pulses 2 cycles after the press event (3 cycles with INPUT_BCD_EN defined).
// Backpressure: busy stalls the processor from request to capture; flagIN low while waiting aborts the request.
// Optional macro INPUT_BCD_EN: read the switches as sign-magnitude BCD through an extra CONVERT state.
module input_unit #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SW_W            = 10,
   parameter int DATA_W          = 32
) (
   input logic        clk,
   input logic        rst_n,
   input_unit_if.slave io
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT_PRESS,
      CAPTURE,
`ifdef INPUT_BCD_EN
      CONVERT,
`endif
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              key_s1;
   logic              key_s2;
   logic              key_db;      // accepted key level, 1 = released
   logic              key_db_d;
   logic [CNT_W-1:0]  db_cnt;
   logic              press_evt;
   logic [DATA_W-1:0] value_q;

   // Two-flop synchroniser for the asynchronous key; resets to released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1 <= 1'b1;
         key_s2 <= 1'b1;
      end else begin
         key_s1 <= io.key_n;
         key_s2 <= key_s1;
      end
   end

   // Debouncer: the accepted level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_db   <= 1'b1;
         key_db_d <= 1'b1;
         db_cnt   <= '0;
      end else begin
         key_db_d <= key_db;
         if (key_s2 == key_db) begin
            db_cnt <= '0;
         end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            key_db <= key_s2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + CNT_W'(1);
         end
      end
   end

   // One-cycle pulse in the first cycle the accepted level reads pressed.
   assign press_evt = key_db_d & ~key_db;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and handshake outputs; a held key must be released before a press counts.
   always_comb begin
      state_nxt   = state;
      io.ready    = 1'b0;
      io.busy     = 1'b0;
      io.wait_led = 1'b0;
      case (state)
         IDLE: begin
            if (io.flagIN) state_nxt = ARM;
         end
         ARM: begin
            io.busy     = 1'b1;
            io.wait_led = 1'b1;
            if (!io.flagIN)  state_nxt = IDLE;
            else if (key_db) state_nxt = WAIT_PRESS;
         end
         WAIT_PRESS: begin
            io.busy     = 1'b1;
            io.wait_led = 1'b1;
            if (!io.flagIN)     state_nxt = IDLE;
            else if (press_evt) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            io.busy = 1'b1;
`ifdef INPUT_BCD_EN
            state_nxt = CONVERT;
`else
            state_nxt = DONE;
`endif
         end
`ifdef INPUT_BCD_EN
         CONVERT: begin
            io.busy   = 1'b1;
            state_nxt = DONE;
         end
`endif
         DONE: begin
            io.ready  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef INPUT_BCD_EN
   logic [SW_W-1:0]   sw_q;
   logic [3:0]        ones;
   logic [3:0]        tens;
   logic [7:0]        bcd_mag;
   logic [DATA_W-1:0] mag_ext;

   // BCD digits clamped to 9, then combined into a 0..199 magnitude.
   always_comb begin
      ones    = (sw_q[3:0] > 4'd9) ? 4'd9 : sw_q[3:0];
      tens    = (sw_q[7:4] > 4'd9) ? 4'd9 : sw_q[7:4];
      bcd_mag = (sw_q[8] ? 8'd100 : 8'd0) + ({4'd0, tens} * 8'd10) + {4'd0, ones};
      mag_ext = {{(DATA_W - 8){1'b0}}, bcd_mag};
   end

   // Switches registered in CAPTURE; the signed result lands in CONVERT and holds until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_q    <= '0;
         value_q <= '0;
      end else begin
         if (state == CAPTURE) sw_q <= io.switches;
         if (state == CONVERT) value_q <= sw_q[SW_W-1] ? (~mag_ext + DATA_W'(1)) : mag_ext;
      end
   end
`else
   // Switches go straight into the value register in CAPTURE, sign-extended from the top switch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else if (state == CAPTURE) begin
         value_q <= {{(DATA_W - SW_W){io.switches[SW_W-1]}}, io.switches};
      end
   end
`endif

   assign io.value = value_q;

endmodule

// File: tb/tb_input_unit.sv
// Self-checking bench for input_unit with a short debounce window.
// Directed requests with literal expected values plus a cycle-by-cycle reference model.
// Build with INPUT_BCD_EN defined to exercise the BCD conversion path.
module tb_input_unit;

   localparam int D = 4;
`ifdef INPUT_BCD_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   input_unit_if #(.SW_W(10), .DATA_W(32)) io ();

   input_unit #(.DEBOUNCE_CYCLES(D), .SW_W(10), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io.slave)
   );

   int n_cmp     = 0;
   int n_err     = 0;
   int ready_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Value the switches must produce, straight from the operand rules.
   function automatic logic [31:0] expect_val(input logic [9:0] sw);
`ifdef INPUT_BCD_EN
      int o, t, mag;
      o   = (int'(sw[3:0]) > 9) ? 9 : int'(sw[3:0]);
      t   = (int'(sw[7:4]) > 9) ? 9 : int'(sw[7:4]);
      mag = 100 * int'(sw[8]) + 10 * t + o;
      return sw[9] ? 32'(-mag) : 32'(mag);
`else
      int s;
      s = int'(sw);
      if (sw[9]) s = s - 1024;
      return 32'(s);
`endif
   endfunction

   // Reference model. mode: 0 no request, 1 waiting for key release, 2 waiting for press, 3 result pending.
   int          m_mode;
   int          to_ready;
   int          run;
   logic        s1, s2, acc, press, press_n;
   logic [9:0]  sw_hold;
   logic [31:0] m_value;

   task automatic model_reset();
      m_mode = 0; to_ready = 0; run = 0;
      s1 = 1'b1; s2 = 1'b1; acc = 1'b1; press = 1'b0;
      sw_hold = '0; m_value = '0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            model_reset();
         end else begin
            case (m_mode)
               0: if (io.flagIN) m_mode = 1;
               1: if (!io.flagIN) m_mode = 0; else if (acc) m_mode = 2;
               2: if (!io.flagIN) m_mode = 0;
                  else if (press) begin m_mode = 3; to_ready = LAT - 1; end
               default: begin
                  if (to_ready == LAT - 1) sw_hold = io.switches;
                  if (to_ready == 1) m_value = expect_val(sw_hold);
                  if (to_ready == 0) m_mode = 0;
                  else to_ready--;
               end
            endcase
            press_n = 1'b0;
            if (s2 != acc) begin
               run++;
               if (run == D) begin
                  press_n = (s2 == 1'b0);
                  acc     = s2;
                  run     = 0;
               end
            end else begin
               run = 0;
            end
            press = press_n;
            s2    = s1;
            s1    = io.key_n;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         check("ready",    32'(io.ready),    32'(m_mode == 3 && to_ready == 0));
         check("busy",     32'(io.busy),     32'(m_mode == 1 || m_mode == 2 || (m_mode == 3 && to_ready != 0)));
         check("wait_led", 32'(io.wait_led), 32'(m_mode == 1 || m_mode == 2));
         check("value",    io.value,         m_value);
         if (io.ready === 1'b1) ready_cnt++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Bounded wait for ready; the processor drops flagIN in the ready cycle.
   task automatic wait_ready(input string name);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk);
         #1;
         if (io.ready === 1'b1) begin
            got = 1'b1;
            check({name, "_busy_in_ready"}, 32'(io.busy), 32'd0);
            io.flagIN = 1'b0;
         end
      end
      check({name, "_ready_seen"}, 32'(got), 32'd1);
   endtask

   task automatic release_key();
      io.key_n = 1'b1;
      cyc(8);
   endtask

   task automatic run_req(input string name, input logic [9:0] sw, input logic [31:0] exp);
      int rc0;
      io.switches = sw;
      rc0 = ready_cnt;
      io.flagIN = 1'b1;
      cyc(3);
      io.key_n = 1'b0;
      wait_ready(name);
      cyc(2);
      check({name, "_value"},  io.value,               exp);
      check({name, "_pulses"}, 32'(ready_cnt - rc0),   32'd1);
      release_key();
   endtask

   initial begin
      int rc0;
      logic [31:0] v_prev;
      io.flagIN   = 1'b0;
      io.switches = '0;
      io.key_n    = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("rst_ready", 32'(io.ready),    32'd0);
      check("rst_busy",  32'(io.busy),     32'd0);
      check("rst_wait",  32'(io.wait_led), 32'd0);
      check("rst_value", io.value,         32'd0);
      cyc(3);
      rst_n = 1'b1;
      cyc(2);

      // Clean press with a small positive value.
      run_req("t1", 10'h005, 32'h0000_0005);

      // All switches on: most negative-looking pattern.
`ifdef INPUT_BCD_EN
      run_req("t2", 10'h3FF, 32'hFFFF_FF39);
`else
      run_req("t2", 10'h3FF, 32'hFFFF_FFFF);
`endif
      check("t2_sign", 32'(io.value[31]), 32'd1);

      // Key already held before the request: must see a release and a fresh press.
      io.switches = 10'h12A;
      io.key_n    = 1'b0;
      cyc(10);
      rc0 = ready_cnt;
      io.flagIN = 1'b1;
      cyc(10);
      check("t3_no_early_ready", 32'(ready_cnt - rc0), 32'd0);
      check("t3_armed_busy",     32'(io.busy),         32'd1);
      check("t3_armed_led",      32'(io.wait_led),     32'd1);
      io.key_n = 1'b1;
      cyc(8);
      io.key_n = 1'b0;
      wait_ready("t3");
      cyc(2);
      check("t3_pulses", 32'(ready_cnt - rc0), 32'd1);
`ifdef INPUT_BCD_EN
      check("t3_value", io.value, 32'h0000_0081);
`else
      check("t3_value", io.value, 32'h0000_012A);
`endif
      release_key();

      // Bouncing key: 3 low, 2 high, then low for good.
      io.switches = 10'h200;
      rc0 = ready_cnt;
      io.flagIN = 1'b1;
      cyc(3);
      io.key_n = 1'b0; cyc(3);
      io.key_n = 1'b1; cyc(2);
      io.key_n = 1'b0; cyc(1);
      wait_ready("t4");
      cyc(2);
      check("t4_pulses", 32'(ready_cnt - rc0), 32'd1);
`ifdef INPUT_BCD_EN
      check("t4_value", io.value, 32'h0000_0000);
`else
      check("t4_value", io.value, 32'hFFFF_FE00);
`endif
      release_key();

      // Abort while waiting for the press: no result, value unchanged.
      v_prev      = io.value;
      io.switches = 10'h0AA;
      rc0 = ready_cnt;
      io.flagIN = 1'b1;
      cyc(4);
      check("t5_waiting", 32'(io.wait_led), 32'd1);
      io.flagIN = 1'b0;
      cyc(2);
      io.key_n = 1'b0;
      cyc(12);
      check("t5_no_ready", 32'(ready_cnt - rc0), 32'd0);
      check("t5_value",    io.value,             v_prev);
      check("t5_idle",     32'(io.busy),         32'd0);
      release_key();

      // Reset in the middle of a wait clears everything at once.
      io.flagIN = 1'b1;
      cyc(4);
      check("t6_waiting", 32'(io.wait_led), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_ready", 32'(io.ready),    32'd0);
      check("t6_busy",  32'(io.busy),     32'd0);
      check("t6_wait",  32'(io.wait_led), 32'd0);
      check("t6_value", io.value,         32'd0);
      io.flagIN = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(2);

      // BCD vectors: -127 and a clamped tens digit.
`ifdef INPUT_BCD_EN
      run_req("t7", 10'h327, 32'hFFFF_FF81);
      run_req("t8", 10'h0C3, 32'h0000_005D);
`else
      run_req("t7", 10'h327, 32'hFFFF_FF27);
      run_req("t8", 10'h0C3, 32'h0000_00C3);
`endif

      cyc(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
